// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and width helpers for the multi-channel ultrasonic ranger.
// Holds the slot FSM state encoding and the width function used to size the ports.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLD
  } state_e;

  localparam int unsigned STATE_W = $bits(state_e);

  // A counter or selector always needs at least one bit, even for a single value.
  function automatic int unsigned clog2Min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Single-bit echo synchroniser: two flops against metastability, a third flop for edge detection.
// rise_o and fall_o are one-cycle pulses aligned to the synchronised level.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 range controller: one trigger per fixed slot, one result per slot.
// The echo width is counted in whole centimetres and reported as a distance or as a timeout.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned TRIG_CYC   = 500,
  parameter int unsigned CYC_PER_CM = 2900,
  parameter int unsigned SLOT_CYC   = 3_000_000,
  parameter int unsigned CM_W       = 12,
  parameter int unsigned MAX_CM     = 400
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_CH-1:0]              echo,
  output logic [N_CH-1:0]              trigger,
  output logic [CM_W-1:0]              dist_cm,
  output logic [clog2Min1(N_CH)-1:0]   dist_ch,
  output logic                         dist_valid,
  output logic                         dist_timeout
);

  localparam int unsigned CH_W  = clog2Min1(N_CH);
  localparam int unsigned SC_W  = clog2Min1(SLOT_CYC);
  localparam int unsigned SUB_W = clog2Min1(CYC_PER_CM);

  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SLOT_CYC - 1);
  localparam logic [SC_W-1:0]  TRIG_LAST = SC_W'(TRIG_CYC - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_MAX    = CM_W'(MAX_CM);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ch_d;
  logic [SC_W-1:0]   sc_q;
  logic [SUB_W-1:0]  sub_q;
  logic [CM_W-1:0]   cm_q;
  logic              reported_q;
  logic [N_CH-1:0]   trigger_q;
  logic [CM_W-1:0]   distCm_q;
  logic [CH_W-1:0]   distCh_q;
  logic              distValid_q;
  logic              distTimeout_q;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   fall;
  logic              riseSel;
  logic              fallSel;
  logic              slotEnd;
  logic              echoWinsAtEnd;

  for (genvar g = 0; g < N_CH; g++) begin : gSync
    echo_sync uSync (
      .clk    (clk),
      .reset  (reset),
      .echo_i (echo[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  function automatic logic [N_CH-1:0] chOneHot(input logic [CH_W-1:0] c);
    logic [N_CH-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    ch_d          = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
    riseSel       = rise[ch_q];
    fallSel       = fall[ch_q];
    slotEnd       = (state_q != IDLE) && (sc_q == SC_LAST);
    echoWinsAtEnd = (state_q == MEASURE) && fallSel;
  end

  // A falling edge in the last slot cycle still reports as a distance; otherwise an
  // unreported slot is closed with a timeout in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      sc_q          <= '0;
      sub_q         <= '0;
      cm_q          <= '0;
      reported_q    <= 1'b0;
      trigger_q     <= '0;
      distCm_q      <= '0;
      distCh_q      <= '0;
      distValid_q   <= 1'b0;
      distTimeout_q <= 1'b0;
    end else begin
      distValid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (enable) begin
          state_q    <= TRIG;
          trigger_q  <= chOneHot(ch_q);
          sc_q       <= '0;
          reported_q <= 1'b0;
        end
      end else begin
        sc_q <= sc_q + SC_W'(1);
        case (state_q)
          TRIG: begin
            if (sc_q == TRIG_LAST) begin
              trigger_q <= '0;
              state_q   <= WAIT_RISE;
            end
          end
          WAIT_RISE: begin
            if (riseSel) begin
              state_q <= MEASURE;
              cm_q    <= '0;
              sub_q   <= '0;
            end
          end
          MEASURE: begin
            if (fallSel) begin
              distCm_q      <= cm_q;
              distCh_q      <= ch_q;
              distTimeout_q <= 1'b0;
              distValid_q   <= 1'b1;
              reported_q    <= 1'b1;
              state_q       <= HOLD;
            end else if (cm_q == CM_MAX) begin
              distCm_q      <= CM_MAX;
              distCh_q      <= ch_q;
              distTimeout_q <= 1'b1;
              distValid_q   <= 1'b1;
              reported_q    <= 1'b1;
              state_q       <= HOLD;
            end else if (sub_q == SUB_LAST) begin
              sub_q <= '0;
              cm_q  <= cm_q + CM_W'(1);
            end else begin
              sub_q <= sub_q + SUB_W'(1);
            end
          end
          default: begin
          end
        endcase

        if (slotEnd) begin
          if (!reported_q && !echoWinsAtEnd) begin
            distCm_q      <= CM_MAX;
            distCh_q      <= ch_q;
            distTimeout_q <= 1'b1;
            distValid_q   <= 1'b1;
          end
          ch_q       <= ch_d;
          sc_q       <= '0;
          reported_q <= 1'b0;
          if (enable) begin
            state_q   <= TRIG;
            trigger_q <= chOneHot(ch_d);
          end else begin
            state_q   <= IDLE;
            trigger_q <= '0;
          end
        end
      end
    end
  end

  assign trigger      = trigger_q;
  assign dist_cm      = distCm_q;
  assign dist_ch      = distCh_q;
  assign dist_valid   = distValid_q;
  assign dist_timeout = distTimeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with short slots; expected values are worked out by hand
// from the echo pulse widths, the 3-cycle report latency and the 2000-cycle slot period.
module tb_ultrasonic_ranger;

  localparam int unsigned N_CH       = 2;
  localparam int unsigned TRIG_CYC   = 5;
  localparam int unsigned CYC_PER_CM = 10;
  localparam int unsigned SLOT_CYC   = 2000;
  localparam int unsigned CM_W       = 12;
  localparam int unsigned MAX_CM     = 100;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [1:0]      echo;
  logic [1:0]      trigger;
  logic [CM_W-1:0] dist_cm;
  logic [0:0]      dist_ch;
  logic            dist_valid;
  logic            dist_timeout;

  int testsRun;
  int testsFailed;
  int cycle;
  int validCount;
  int lastValidCycle;
  int lastCm;
  int lastCh;
  int lastTo;
  int trigRiseCount [2];
  int trigRiseCycle [2];
  int multiHotCount;
  logic [1:0] prevTrig;

  ultrasonic_ranger #(
    .N_CH       (N_CH),
    .TRIG_CYC   (TRIG_CYC),
    .CYC_PER_CM (CYC_PER_CM),
    .SLOT_CYC   (SLOT_CYC),
    .CM_W       (CM_W),
    .MAX_CM     (MAX_CM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .echo         (echo),
    .trigger      (trigger),
    .dist_cm      (dist_cm),
    .dist_ch      (dist_ch),
    .dist_valid   (dist_valid),
    .dist_timeout (dist_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Records every report and every trigger rise at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dist_valid) begin
      validCount     = validCount + 1;
      lastValidCycle = cycle;
      lastCm         = int'(dist_cm);
      lastCh         = int'(dist_ch);
      lastTo         = int'(dist_timeout);
    end
    for (int i = 0; i < 2; i++) begin
      if (trigger[i] && !prevTrig[i]) begin
        trigRiseCount[i] = trigRiseCount[i] + 1;
        trigRiseCycle[i] = cycle;
      end
    end
    if (trigger == 2'b11) multiHotCount = multiHotCount + 1;
    prevTrig = trigger;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitTrigRise(input int ch, input string tag);
    int startCount;
    bit seen;
    startCount = trigRiseCount[ch];
    seen = 1'b0;
    for (int i = 0; i < 3 * SLOT_CYC; i++) begin
      step();
      if (trigRiseCount[ch] != startCount) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput(tag, 0, 1);
  endtask

  task automatic applyStimulus(input int ch, input int highCycles, output int riseCycle,
                               output int fallCycle);
    echo[ch] = 1'b1;
    riseCycle = cycle;
    repeat (highCycles) step();
    echo[ch] = 1'b0;
    fallCycle = cycle;
  endtask

  initial begin
    int t0a, t0b, t1, r, f, v0, highCnt, nonZero;
    testsRun = 0; testsFailed = 0; cycle = 0; validCount = 0; lastValidCycle = -1;
    lastCm = -1; lastCh = -1; lastTo = -1; multiHotCount = 0; prevTrig = 2'b00;
    trigRiseCount[0] = 0; trigRiseCount[1] = 0; trigRiseCycle[0] = 0; trigRiseCycle[1] = 0;
    reset = 1'b1; enable = 1'b1; echo = 2'b00;

    // 1. Reset holds everything low even with toggling echoes; trigger[0] lasts 5 cycles.
    for (int i = 0; i < 20; i++) begin
      echo = echo ^ 2'b11;
      step();
    end
    checkOutput("rst_trigger", int'(trigger), 0);
    checkOutput("rst_dist_cm", int'(dist_cm), 0);
    checkOutput("rst_dist_ch", int'(dist_ch), 0);
    checkOutput("rst_timeout", int'(dist_timeout), 0);
    checkOutput("rst_valid_cnt", validCount, 0);
    echo = 2'b00;
    repeat (4) step();
    reset = 1'b0;
    waitTrigRise(0, "first_trig_timeout");
    t0a = trigRiseCycle[0];
    checkOutput("first_trig_onehot", int'(trigger), 1);
    highCnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!trigger[0]) break;
      highCnt++;
      step();
    end
    checkOutput("trig_high_cycles", highCnt, 5);

    // 2. ch0 echo 255 cycles wide -> 25 cm, three cycles after the pin falls.
    repeat (3) step();
    applyStimulus(0, 255, r, f);
    repeat (10) step();
    checkOutput("ch0_valid_cnt", validCount, 1);
    checkOutput("ch0_cm", lastCm, 25);
    checkOutput("ch0_ch", lastCh, 0);
    checkOutput("ch0_timeout", lastTo, 0);
    checkOutput("ch0_latency", lastValidCycle - f, 3);
    checkOutput("ch0_hold_cm", int'(dist_cm), 25);

    // 3. ch1 never echoes -> timeout closes the slot together with the wrap to ch0.
    waitTrigRise(1, "ch1_trig_timeout");
    t1 = trigRiseCycle[1];
    waitTrigRise(0, "wrap_trig_timeout");
    t0b = trigRiseCycle[0];
    checkOutput("slot0_len", t1 - t0a, 2000);
    checkOutput("slot1_len", t0b - t1, 2000);
    checkOutput("ch1_valid_cnt", validCount, 2);
    checkOutput("ch1_cm", lastCm, 100);
    checkOutput("ch1_ch", lastCh, 1);
    checkOutput("ch1_timeout", lastTo, 1);
    checkOutput("ch1_report_cycle", lastValidCycle, t0b);

    // 4. ch0 echo 1500 cycles saturates at 100 cm; ch1 echo already high at trigger time.
    repeat (8) step();
    applyStimulus(0, 1500, r, f);
    echo[1] = 1'b1;
    checkOutput("sat_cm", lastCm, 100);
    checkOutput("sat_timeout", lastTo, 1);
    checkOutput("sat_ch", lastCh, 0);
    checkOutput("sat_report_cycle", lastValidCycle - r, 1004);
    waitTrigRise(1, "sat_ch1_trig_timeout");
    checkOutput("sat_single_valid", validCount, 3);
    waitTrigRise(0, "stuck_wrap_timeout");
    echo[1] = 1'b0;
    checkOutput("stuck_valid_cnt", validCount, 4);
    checkOutput("stuck_cm", lastCm, 100);
    checkOutput("stuck_ch", lastCh, 1);
    checkOutput("stuck_timeout", lastTo, 1);
    checkOutput("stuck_report_cycle", lastValidCycle, trigRiseCycle[0]);

    // 5. Reset in the middle of a ch1 measurement clears outputs at once; restart on ch0.
    waitTrigRise(1, "mid_ch1_trig_timeout");
    repeat (8) step();
    echo[1] = 1'b1;
    repeat (100) step();
    reset = 1'b1;
    #1;
    checkOutput("midrst_trigger", int'(trigger), 0);
    checkOutput("midrst_dist_cm", int'(dist_cm), 0);
    checkOutput("midrst_dist_ch", int'(dist_ch), 0);
    checkOutput("midrst_timeout", int'(dist_timeout), 0);
    echo[1] = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    waitTrigRise(0, "post_rst_trig_timeout");
    checkOutput("post_rst_trigger", int'(trigger), 1);

    // 6. enable drops mid-slot: ch0 still reports, then silence, then resume on ch1.
    repeat (8) step();
    echo[0] = 1'b1;
    r = cycle;
    v0 = validCount;
    repeat (20) step();
    enable = 1'b0;
    repeat (135) step();
    echo[0] = 1'b0;
    f = cycle;
    nonZero = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (trigger != 2'b00) nonZero++;
    end
    checkOutput("dis_valid_cnt", validCount - v0, 1);
    checkOutput("dis_cm", lastCm, 15);
    checkOutput("dis_ch", lastCh, 0);
    checkOutput("dis_timeout", lastTo, 0);
    checkOutput("dis_latency", lastValidCycle - f, 3);
    checkOutput("dis_no_trigger", nonZero, 0);
    enable = 1'b1;
    waitTrigRise(1, "resume_trig_timeout");
    checkOutput("resume_trigger", int'(trigger), 2);
    checkOutput("trigger_onehot", multiHotCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
